// File: rtl/reg_file_port_ctrl.sv
// reg_file_port_ctrl: arbitrates a single-port register file between operand reads and buffered writebacks
module reg_file_port_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 16,
    parameter int WB_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rs_data,
    output logic [DATA_W-1:0] rsp_rt_data,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_rd_data,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data
);
    localparam int PTR_W = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   rs_q, rt_q, last_rd;
    logic [DATA_W-1:0]   last_data;
    logic [ADDR_W-1:0]   fifo_rd   [WB_DEPTH];
    logic [DATA_W-1:0]   fifo_data [WB_DEPTH];
    logic [WB_DEPTH-1:0] occ, set_m, clr_m;
    logic [PTR_W-1:0]    head, tail;
    logic                hazard, push, pop, rs_ok, rt_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a != '0 && int'(a) <= NUM_REGS;
    endfunction

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign rs_ok = addr_ok(rs_q);
    assign rt_ok = addr_ok(rt_q);

    // Slots carry their own occupancy bit so hazard search needs no pointer arithmetic
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++)
            if (occ[i] && ((rs_ok && fifo_rd[i] == rs_q) || (rt_ok && fifo_rd[i] == rt_q)))
                hazard = 1'b1;
    end

    assign wb_ready  = ~&occ;
    assign push      = wb_valid && wb_ready && addr_ok(wb_rd);
    assign pop       = |occ && !(state == ISSUE && !hazard);
    assign set_m     = push ? WB_DEPTH'(1) << tail : '0;
    assign clr_m     = pop ? WB_DEPTH'(1) << head : '0;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rf_rw     = pop;
    assign rf_rs     = rs_q;
    assign rf_rt     = rt_q;
    assign rf_rd      = pop ? fifo_rd[head] : last_rd;
    assign rf_rd_data = pop ? fifo_data[head] : last_data;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = req_valid ? ISSUE : IDLE;
            ISSUE:   state_nx = hazard ? ISSUE : CAPTURE;
            CAPTURE: state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rs_q        <= '0;
            rt_q        <= '0;
            last_rd     <= '0;
            last_data   <= '0;
            occ         <= '0;
            head        <= '0;
            tail        <= '0;
            rsp_rs_data <= '0;
            rsp_rt_data <= '0;
        end else begin
            state <= state_nx;
            occ   <= (occ | set_m) & ~clr_m;
            if (state == IDLE && req_valid) begin
                rs_q <= req_rs;
                rt_q <= req_rt;
            end
            if (state == CAPTURE) begin
                rsp_rs_data <= rs_ok ? rf_rs_data : '0;
                rsp_rt_data <= rt_ok ? rf_rt_data : '0;
            end
            if (pop) begin
                head      <= nxt(head);
                last_rd   <= fifo_rd[head];
                last_data <= fifo_data[head];
            end
            if (push)
                tail <= nxt(tail);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= wb_rd;
            fifo_data[tail] <= wb_data;
        end
    end
endmodule

// File: tb/tb_reg_file_port_ctrl.sv
// tb_reg_file_port_ctrl: scoreboard bench with a registered single-port register file model
module tb_reg_file_port_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, req_valid, req_ready, rsp_valid, rsp_ready, wb_valid, wb_ready, rf_rw;
    logic [4:0] req_rs, req_rt, wb_rd, rf_rs, rf_rt, rf_rd;
    logic [7:0] rsp_rs_data, rsp_rt_data, wb_data, rf_rd_data, rf_rs_data, rf_rt_data;

    always #5 clk = ~clk;

    reg_file_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rw(rf_rw), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data)
    );

    typedef struct {
        logic [7:0] rs;
        logic [7:0] rt;
        int         lat;
        int         hs;
    } exp_t;

    exp_t       sb[$];
    exp_t       em;
    logic [7:0] mem [32];
    int         cyc = 0;
    int         wr_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    int         w;
    logic       rsp_seen = 1'b0;

    // Every register starts at 0xC0+index so masked reads are distinguishable from real ones
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0)
            for (int i = 0; i < 32; i++) mem[i] <= 8'hC0 + 8'(i);
        else if (rf_rw)
            mem[rf_rd] <= rf_rd_data;
        else begin
            rf_rs_data <= mem[rf_rs];
            rf_rt_data <= mem[rf_rt];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rf_rw) wr_cnt++;
        if (rsp_valid && !rsp_seen) begin
            if (sb.size() == 0)
                check("rsp_unexpected", 32'(rsp_valid), 0);
            else begin
                em = sb.pop_front();
                check("rsp_rs", 32'(rsp_rs_data), 32'(em.rs));
                check("rsp_rt", 32'(rsp_rt_data), 32'(em.rt));
                check("rsp_lat", 32'(cyc - em.hs), 32'(em.lat));
            end
        end
        rsp_seen = rsp_valid && !rsp_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [7:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        while (!wb_ready && n < 20) begin tick(); n++; end
        check("wb_accept", 32'(wb_ready), 1);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic do_req(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [7:0] ers, input logic [7:0] ert, input int lat);
        int n = 0;
        req_valid = 1'b1; req_rs = rs; req_rt = rt;
        while (!req_ready && n < 20) begin tick(); n++; end
        check("req_accept", 32'(req_ready), 1);
        sb.push_back('{ers, ert, lat, cyc});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 40) begin tick(); n++; end
        check("rsp_timeout", 32'(n < 40), 1);
        sb.delete();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rs = '0; req_rt = '0; rsp_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (3) tick();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'({rsp_rs_data, rsp_rt_data}), 0);
        check("rst_rf_rw", 32'(rf_rw), 0);
        check("rst_rf_addr", 32'({rf_rs, rf_rt, rf_rd}), 0);
        check("rst_rf_data", 32'(rf_rd_data), 0);
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_wb_ready", 32'(wb_ready), 1);

        // simple write then read with a masked rt
        w = wr_cnt;
        do_wb(5'd3, 8'hA5);
        do_req(5'd3, 5'd0, 8'hA5, 8'h00, 3);
        wait_rsp();
        check("t1_writes", 32'(wr_cnt - w), 1);

        // two hazard entries ahead of the read
        req_valid = 1'b1; req_rs = 5'd6; req_rt = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 8'h3C;
        sb.push_back('{8'h11, 8'h3C, 5, cyc});
        tick();
        req_valid = 1'b0; wb_rd = 5'd6; wb_data = 8'h11;
        check("t2_wb_ready", 32'(wb_ready), 1);
        tick();
        wb_valid = 1'b0;
        wait_rsp();

        // FIFO fills while the read owns the port, response held under backpressure
        w = wr_cnt;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_rs = 5'd1; req_rt = 5'd2;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 8'h99;
        sb.push_back('{8'hC1, 8'hC2, 3, cyc});
        tick();
        req_valid = 1'b0; wb_rd = 5'd10; wb_data = 8'hAA;
        check("t3_wb_ready_issue", 32'(wb_ready), 1);
        tick();
        check("t3_wb_ready_full", 32'(wb_ready), 0);
        wb_rd = 5'd11; wb_data = 8'hBB;
        tick();
        check("t3_wb_ready_drained", 32'(wb_ready), 1);
        tick();
        wb_valid = 1'b0;
        repeat (2) begin
            check("t3_rsp_valid_hold", 32'(rsp_valid), 1);
            check("t3_rsp_data_hold", 32'({rsp_rs_data, rsp_rt_data}), 32'h0000C1C2);
            check("t3_req_ready_low", 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_rsp();
        check("t3_writes", 32'(wr_cnt - w), 3);
        do_req(5'd9, 5'd10, 8'h99, 8'hAA, 3);
        wait_rsp();
        do_req(5'd11, 5'd0, 8'hBB, 8'h00, 3);
        wait_rsp();

        // out-of-range and register-0 writebacks are acknowledged but dropped
        w = wr_cnt;
        do_wb(5'd0, 8'hFF);
        do_wb(5'd20, 8'h77);
        repeat (3) tick();
        check("t4_no_writes", 32'(wr_cnt - w), 0);
        do_req(5'd20, 5'd0, 8'h00, 8'h00, 3);
        wait_rsp();

        // writeback in the read's issue cycle is younger than the read
        req_valid = 1'b1; req_rs = 5'd7; req_rt = 5'd7;
        sb.push_back('{8'hC7, 8'hC7, 3, cyc});
        tick();
        req_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 8'h42;
        check("t5_wb_ready", 32'(wb_ready), 1);
        tick();
        wb_valid = 1'b0;
        wait_rsp();
        do_req(5'd7, 5'd3, 8'h42, 8'hA5, 3);
        wait_rsp();

        // reset during CAPTURE with a buffered write
        req_valid = 1'b1; req_rs = 5'd1; req_rt = 5'd2;
        tick();
        req_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 8'h5A;
        tick();
        wb_valid = 1'b0;
        check("t6_capture_write", 32'(rf_rw), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rf_rw", 32'(rf_rw), 0);
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_rsp_data", 32'({rsp_rs_data, rsp_rt_data}), 0);
        check("t6_rf_addr", 32'({rf_rs, rf_rt, rf_rd}), 0);
        check("t6_rf_data", 32'(rf_rd_data), 0);
        w = wr_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("t6_no_writes", 32'(wr_cnt - w), 0);
        check("t6_req_ready", 32'(req_ready), 1);
        check("t6_wb_ready", 32'(wb_ready), 1);
        do_req(5'd12, 5'd1, 8'hCC, 8'hC1, 3);
        wait_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_port_ctrl.md
# reg_file_port_ctrl

Access controller that sits between the decode/writeback pipeline and the single-port 8-bit, 16-entry register file. The register file uses one `rw` strobe, so each cycle is either a two-operand read or one write. This block arbitrates those cycles, buffers writebacks in a small FIFO and stalls reads on read-after-write hazards. It returns operand pairs through a valid/ready handshake, and it owns register-0 and out-of-range masking so that no caller depends on register-file address checks.

## Interface
Parameters:
- `DATA_W`, 8, register data width
- `ADDR_W`, 5, register address width
- `NUM_REGS`, 16, highest valid register index (valid range is 1..NUM_REGS)
- `WB_DEPTH`, 2, writeback FIFO entries (≥1)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  operand read request
- `req_ready`  out  1  request accepted when both valid and ready are high
- `req_rs`, `req_rt`  in  ADDR_W  operand addresses
- `rsp_valid`  out  1  operand pair available
- `rsp_ready`  in  1  consumer takes the response
- `rsp_rs_data`, `rsp_rt_data`  out  DATA_W  operand values
- `wb_valid`  in  1  writeback request
- `wb_ready`  out  1  writeback accepted when both valid and ready are high
- `wb_rd`  in  ADDR_W  destination register
- `wb_data`  in  DATA_W  write value
- `rf_rw`  out  1  register-file strobe; 1 = write cycle, 0 = read cycle
- `rf_rs`, `rf_rt`, `rf_rd`  out  ADDR_W  register-file addresses
- `rf_rd_data`  out  DATA_W  register-file write data
- `rf_rs_data`, `rf_rt_data`  in  DATA_W  register-file read data; registered, valid the cycle after a read cycle

## Operation
- Valid address: 1 ≤ addr ≤ NUM_REGS. Any other address reads as 0 and is never written.
- Writeback FIFO:
  - A write with a valid `wb_rd` is pushed on handshake. A write with an invalid `wb_rd` is acknowledged and discarded.
  - `wb_ready` = FIFO not full. Push and pop in the same cycle are legal.
- Request FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: `req_ready`=1. On handshake, latch `req_rs` and `req_rt`, go to ISSUE.
  - ISSUE:
    - Hazard means any FIFO entry targets the latched rs or rt. A hazard only counts for a valid address.
    - With a hazard, issue a write cycle from the FIFO head and stay in ISSUE.
    - Without a hazard, drive `rf_rw`=0 with `rf_rs` and `rf_rt` set to the latched addresses, go to CAPTURE.
  - CAPTURE: register `rf_rs_data` and `rf_rt_data` into the response registers, substituting 0 for an invalid address. Go to RESP.
  - RESP: `rsp_valid`=1 and the data are held stable. On `rsp_ready`, go to IDLE.
- Cycle arbitration:
  - The ISSUE read cycle (no hazard) wins over pending writes.
  - In IDLE, CAPTURE, RESP, and in ISSUE under a hazard, a non-empty FIFO pops one entry: `rf_rw`=1, `rf_rd` and `rf_rd_data` from the head.
  - A write in the CAPTURE cycle is legal, because the register-file read outputs are not updated on write cycles.
- Ordering:
  - A writeback accepted in the same cycle the read is issued is younger than that read, so the read returns the old value.
  - Writes to the same register drain in FIFO order.
- When idle, `rf_rw`=0 and the address outputs are held at their last values. This is a harmless read cycle.

## Timing
- Reset (`rst_n` low, asynchronous):
  - FSM goes to IDLE and the FIFO is emptied.
  - `rsp_valid`=0, `rsp_rs_data`=`rsp_rt_data`=0.
  - `rf_rw`=0 and all `rf_*` address and data outputs are 0.
  - `req_ready`=1 and `wb_ready`=1 once reset is released.
- Reset mid-operation drops the in-flight request and all buffered writes. No write is issued after release.
- Read latency with no hazard:
  - Handshake at edge E.
  - ISSUE in cycle E+1, CAPTURE in cycle E+2.
  - `rsp_valid` high in cycle E+3.
- Each hazard entry ahead of the matching write adds one cycle.
- Throughput: one request per 4 cycles when `rsp_ready` is held high.
- `req_ready` is low from ISSUE until the RESP handshake completes.
- Write drain: at most one write per cycle. Worst-case FIFO drain is WB_DEPTH cycles.

## Test plan
- Reset, wb rd=3 data 0xA5, then read rs=3 rt=0 -> one `rf_rw`=1 cycle, then `rsp_valid` 3 cycles after the request handshake with rs=0xA5, rt=0x00.
- Fill FIFO with rd=5/0x3C and rd=6/0x11 in the same cycle as a read request rs=6 rt=5 -> writes issue before the read cycle, response 0x11/0x3C, latency 5 cycles.
- Hold `rsp_ready`=0 and offer three writebacks -> `wb_ready` drops when 2 entries are buffered, the third is accepted after a drain cycle, `rsp_*` stay stable and `req_ready`=0.
- wb rd=0 data 0xFF and wb rd=20 data 0x77 -> both acknowledged, no `rf_rw`=1 cycle, then read rs=20 rt=0 -> 0x00/0x00.
- Writeback rd=7/0x42 accepted in the ISSUE cycle of read rs=7 -> response carries the prior value of reg 7; the next read returns 0x42.
- Pull `rst_n` low during CAPTURE with one FIFO entry -> outputs zero immediately, no write issued after release, `req_ready`=1 and `wb_ready`=1.
